// File: rtl/packet_buffer_reader.sv
// packet_buffer_reader
//   Streams a (start address, length) window out of the packet-buffer BRAM.
//   One read per cycle goes to the BRAM driver. Returning bytes land in a small
//   FIFO. A credit check bounds reads in flight plus bytes buffered, so that a
//   stalled consumer never overflows the FIFO.
// Ports
//   clk, reset          clock, synchronous active-low reset
//   start/start_addr/len  command strobe (taken only when idle), first address, byte count
//   busy, done          command active, one-cycle completion pulse
//   ram_read_*          read strobe/address out, data-valid strobe/data back from the driver
//   out_valid/out_data/out_last/out_ready  byte stream with final-byte flag and backpressure
module packet_buffer_reader #(
  parameter int RAM_SIZE     = 4096,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  localparam int AW = $clog2(RAM_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          ram_read_req,
  output logic [AW-1:0] ram_read_addr,
  input  logic          ram_read_ready,
  input  logic [7:0]    ram_read_data,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_last,
  input  logic          out_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   CREDITS   = (CW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] ADDR_LAST = AW'(RAM_SIZE - 1);
  localparam logic [AW:0]   ONE       = (AW+1)'(1);

  // A FIFO shallower than READ_LATENCY+1 still works, but cannot sustain
  // one byte per cycle. This block only marks that configuration in the hierarchy.
  if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_fifo_below_full_rate
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_next;

  logic [AW-1:0] addr;
  logic [AW:0]   remaining, emitted, len_q;
  logic [CW-1:0] inflight, fifo_count;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          issue, push, pop, last_pop, accept, zero_cmd;

  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (emitted == len_q - ONE);

  always_comb begin
    // Returns are only believed while a read is outstanding. This drops
    // stragglers from reads issued before a reset.
    push     = ram_read_ready && (inflight != '0);
    pop      = out_valid && out_ready;
    last_pop = pop && out_last;
    accept   = (state == IDLE) && start && (len != '0);
    zero_cmd = (state == IDLE) && start && (len == '0);
    // A byte leaving the FIFO on this edge returns its credit immediately.
    // Without this, a bubble appears every FIFO_DEPTH reads at full rate.
    issue    = (state == ISSUE) && (remaining != '0) &&
               (({1'b0, inflight} + {1'b0, fifo_count}) < (CREDITS + {{CW{1'b0}}, pop}));
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (issue && remaining == ONE) state_next = DRAIN;
      DRAIN:   if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      ram_read_req  <= 1'b0;
      ram_read_addr <= '0;
      addr          <= '0;
      remaining     <= '0;
      emitted       <= '0;
      len_q         <= '0;
      inflight      <= '0;
      fifo_count    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      done         <= zero_cmd || last_pop;
      ram_read_req <= issue;
      if (accept) begin
        addr      <= start_addr;
        remaining <= len;
        len_q     <= len;
        emitted   <= '0;
        busy      <= 1'b1;
      end
      if (last_pop) busy <= 1'b0;
      if (issue) begin
        ram_read_addr <= addr;
        addr          <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
        remaining     <= remaining - ONE;
      end
      if (pop) emitted <= emitted + ONE;
      case ({issue, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
      if (push) begin
        fifo_mem[wr_ptr] <= ram_read_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_buffer_reader.sv
// Bench for packet_buffer_reader. A table of commands is run against a
// fixed-latency BRAM driver model. A negedge monitor logs reads, pops and done
// pulses. Hand-written sequences cover the reset-time checks and a mid-command abort.
module tb_packet_buffer_reader;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset, start, out_ready, inj_ready;
  logic [11:0] start_addr;
  logic [12:0] len;
  logic        busy, done, ram_read_req, ram_read_ready, out_valid, out_last;
  logic [11:0] ram_read_addr;
  logic [7:0]  ram_read_data, out_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  packet_buffer_reader dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .ram_read_req(ram_read_req), .ram_read_addr(ram_read_addr),
    .ram_read_ready(ram_read_ready), .ram_read_data(ram_read_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  function automatic logic [7:0] bram(input logic [11:0] a);
    return a[7:0] ^ {4'hA, a[11:8]};
  endfunction

  // Driver model: data appears LAT cycles after the request cycle. It is not
  // reset, so reads issued before a reset still come back afterwards.
  logic [LAT-1:0] vld_pipe = '0;
  logic [11:0]    addr_pipe [LAT];
  always @(posedge clk) begin
    vld_pipe     <= {vld_pipe[LAT-2:0], ram_read_req};
    addr_pipe[0] <= ram_read_addr;
    for (int i = 1; i < LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign ram_read_ready = vld_pipe[LAT-1] | inj_ready;
  assign ram_read_data  = vld_pipe[LAT-1] ? bram(addr_pipe[LAT-1]) : 8'h5A;

  typedef struct { logic [7:0] d; logic l; int c; } pop_t;
  pop_t        pop_q[$];
  logic [11:0] req_q[$];
  int          done_q[$];
  int          cyc = 0, busy_cnt = 0, valid_cnt = 0, stall_err = 0, outs_viol = 0, outs = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      if (ram_read_req) req_q.push_back(ram_read_addr);
      if (out_valid && out_ready) pop_q.push_back(pop_t'{out_data, out_last, cyc});
      if (done) done_q.push_back(cyc);
      if (busy) busy_cnt <= busy_cnt + 1;
      if (out_valid) valid_cnt <= valid_cnt + 1;
      if (prev_stall && !(out_valid && out_data == prev_data)) stall_err <= stall_err + 1;
      if (outs + int'(ram_read_req) > 4) outs_viol <= outs_viol + 1;
      outs <= outs + int'(ram_read_req) - int'(out_valid && out_ready);
    end else begin
      outs <= 0;
    end
    prev_stall <= reset && out_valid && !out_ready;
    prev_data  <= out_data;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_req"}, int'(ram_read_req), 0);
    chk({nm, "_addr"}, int'(ram_read_addr), 0);
    chk({nm, "_valid"}, int'(out_valid), 0);
    chk({nm, "_last"}, int'(out_last), 0);
    chk({nm, "_data"}, int'(out_data), 0);
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [12:0] len;
    int          stall;          // 1: out_ready follows 1,0,0,1 repeating
    bit          poke;           // pulse another start while busy
    logic [11:0] exp_last_addr;
    logic [7:0]  exp_first;
    string       nm;
  } vec_t;

  task automatic run_cmd(input vec_t v);
    int rb, pb, db, sb, ob, bb, vb, t0, k, nreq, npop;
    logic [11:0] a;
    rb = req_q.size(); pb = pop_q.size(); db = done_q.size();
    sb = stall_err; ob = outs_viol; bb = busy_cnt; vb = valid_cnt;
    start = 1'b1; start_addr = v.addr; len = v.len; out_ready = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0;
    k = 1;
    while (done_q.size() == db && k < 400) begin
      start = v.poke && (k == 3);
      if (start) begin start_addr = 12'h300; len = 13'd9; end
      out_ready = (v.stall == 0) || (k % 4 == 0) || (k % 4 == 3);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0; out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    nreq = req_q.size() - rb;
    npop = pop_q.size() - pb;
    chk({v.nm, "_done_within_budget"}, int'(k < 400), 1);
    chk({v.nm, "_req_count"}, nreq, int'(v.len));
    for (int i = 0; i < nreq && i < int'(v.len); i++) begin
      a = v.addr + 12'(i);
      chk($sformatf("%s_req_addr%0d", v.nm, i), int'(req_q[rb+i]), int'(a));
    end
    chk({v.nm, "_pop_count"}, npop, int'(v.len));
    for (int i = 0; i < npop && i < int'(v.len); i++) begin
      a = v.addr + 12'(i);
      chk($sformatf("%s_data%0d", v.nm, i), int'(pop_q[pb+i].d), int'(bram(a)));
      chk($sformatf("%s_last%0d", v.nm, i), int'(pop_q[pb+i].l), int'(i == int'(v.len) - 1));
    end
    chk({v.nm, "_done_pulses"}, done_q.size() - db, 1);
    chk({v.nm, "_stall_hold_errors"}, stall_err - sb, 0);
    chk({v.nm, "_credit_overruns"}, outs_viol - ob, 0);
    chk({v.nm, "_busy_after"}, int'(busy), 0);
    if (v.len == 0) begin
      if (done_q.size() > db) chk({v.nm, "_done_cycle"}, done_q[db], t0);
      chk({v.nm, "_busy_cycles"}, busy_cnt - bb, 0);
      chk({v.nm, "_valid_cycles"}, valid_cnt - vb, 0);
    end else begin
      chk({v.nm, "_busy_seen"}, int'(busy_cnt - bb > 0), 1);
      if (nreq > 0) chk({v.nm, "_last_req_addr"}, int'(req_q[rb+nreq-1]), int'(v.exp_last_addr));
      if (npop > 0) begin
        chk({v.nm, "_first_byte"}, int'(pop_q[pb].d), int'(v.exp_first));
        if (done_q.size() > db)
          chk({v.nm, "_done_after_last_pop"}, done_q[db], pop_q[pb+npop-1].c + 1);
        if (v.stall == 0)
          chk({v.nm, "_back_to_back_pops"}, pop_q[pb+npop-1].c - pop_q[pb].c, npop - 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];
  vec_t post;

  initial begin
    int rb, k, vb2, db2;
    vecs[0] = '{12'h010, 13'd5,  0, 1'b0, 12'h014, 8'hB0, "basic"};
    vecs[1] = '{12'hFFE, 13'd4,  0, 1'b0, 12'h001, 8'h51, "wrap"};
    vecs[2] = '{12'h100, 13'd16, 1, 1'b0, 12'h10F, 8'hA1, "stall"};
    vecs[3] = '{12'h020, 13'd0,  0, 1'b0, 12'h000, 8'h00, "zero_len"};
    vecs[4] = '{12'h7FF, 13'd1,  0, 1'b0, 12'h7FF, 8'h58, "single"};
    vecs[5] = '{12'h040, 13'd6,  0, 1'b1, 12'h045, 8'hE0, "restart_ignored"};
    post    = '{12'h123, 13'd2,  0, 1'b0, 12'h124, 8'h82, "post_reset"};

    reset = 1'b0; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b0; inj_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

    // Abort an 8-byte command after its first few reads
    rb = req_q.size();
    start = 1'b1; start_addr = 12'h200; len = 13'd8; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (req_q.size() - rb < 3 && k < 50) begin @(posedge clk); #1; k++; end
    chk("abort_reads_started", int'(req_q.size() - rb >= 3), 1);
    chk("abort_mid_command", int'(req_q.size() - rb < 8), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("abort");
    vb2 = valid_cnt; db2 = done_q.size();
    for (int i = 0; i < 8; i++) begin
      inj_ready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    inj_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_stale_valid", valid_cnt - vb2, 0);
    chk("abort_no_done", done_q.size() - db2, 0);
    chk("abort_busy", int'(busy), 0);
    run_cmd(post);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
